// File: rtl/fifo_ram_ctrl_if.sv
// Producer/consumer handshake bundle for fifo_ram_ctrl.
// Producer drives in_valid/in_data; consumer drives pop.
interface fifo_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  pop;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output in_valid, in_data, pop,
        input  in_ready, out_valid, out_data,
        input  full, empty, count
    );

    modport slave (
        input  in_valid, in_data, pop,
        output in_ready, out_valid, out_data,
        output full, empty, count
    );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller over an external single-port RAM with registered read.
// One RAM access per cycle; a pop wins over a push.
module fifo_ram_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_ram_ctrl_if.slave        bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT =
        {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rd_pend;

    logic empty;
    logic full;
    logic pop_acc;
    logic push_acc;
    logic in_ready;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_acc  = bus.pop & ~empty;
    assign in_ready = ~full & ~pop_acc;
    assign push_acc = bus.in_valid & in_ready;

    always_comb begin
        ram_wr_en = 1'b0;
        ram_addr  = rd_ptr;
        ram_wdata = bus.in_data;
        if (push_acc) begin
            ram_wr_en = 1'b1;
            ram_addr  = wr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= pop_acc;
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                count  <= count - (ADDR_WIDTH+1)'(1);
            end else if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                count  <= count + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Read data arrives one cycle after the pop, straight from the RAM.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = rd_pend;
    assign bus.out_data  = ram_rdata;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count;
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Testbench for fifo_ram_ctrl: RAM model plus queue-based reference.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fifo_ram_ctrl;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] mem [DEPTH];

    int vectors;
    int errors;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [AW-1:0] m_wptr;
    logic [AW-1:0] m_rptr;
    bit            m_pend;
    logic [DW-1:0] m_pdata;

    fifo_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fifo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        else           ram_rdata     <= mem[ram_addr];
    end

    task automatic model_reset();
        q.delete();
        m_wptr = '0;
        m_rptr = '0;
        m_pend = 0;
        m_pdata = '0;
    endtask

    task automatic check_state(input string tag);
        logic [AW:0] ecnt;
        ecnt = (AW+1)'(q.size());
        vectors++;
        if (bus.count !== ecnt) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", tag, bus.count, ecnt);
        end
        vectors++;
        if (bus.empty !== (q.size() == 0)) begin
            errors++;
            $display("FAIL %s empty: got %b want %b", tag, bus.empty, q.size() == 0);
        end
        vectors++;
        if (bus.full !== (q.size() == DEPTH)) begin
            errors++;
            $display("FAIL %s full: got %b want %b", tag, bus.full, q.size() == DEPTH);
        end
        vectors++;
        if (bus.out_valid !== m_pend) begin
            errors++;
            $display("FAIL %s out_valid: got %b want %b", tag, bus.out_valid, m_pend);
        end
        if (m_pend) begin
            vectors++;
            if (bus.out_data !== m_pdata) begin
                errors++;
                $display("FAIL %s out_data: got %h want %h", tag, bus.out_data, m_pdata);
            end
        end
    endtask

    // One clock cycle: drive, check against model, advance model at the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit p,
                        input string tag);
        bit pop_acc, rdy, push_acc;
        logic [AW-1:0] eaddr;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.pop      = p;
        #1;
        pop_acc  = p && q.size() != 0;
        rdy      = q.size() != DEPTH && !pop_acc;
        push_acc = v && rdy;
        eaddr    = push_acc ? m_wptr : m_rptr;
        check_state(tag);
        vectors++;
        if (bus.in_ready !== rdy) begin
            errors++;
            $display("FAIL %s in_ready: got %b want %b", tag, bus.in_ready, rdy);
        end
        vectors++;
        if (ram_wr_en !== push_acc) begin
            errors++;
            $display("FAIL %s ram_wr_en: got %b want %b", tag, ram_wr_en, push_acc);
        end
        vectors++;
        if (ram_addr !== eaddr) begin
            errors++;
            $display("FAIL %s ram_addr: got %0d want %0d", tag, ram_addr, eaddr);
        end
        if (push_acc) begin
            vectors++;
            if (ram_wdata !== d) begin
                errors++;
                $display("FAIL %s ram_wdata: got %h want %h", tag, ram_wdata, d);
            end
        end
        @(posedge clk);
        m_pend = pop_acc;
        if (pop_acc) begin
            m_pdata = q.pop_front();
            m_rptr++;
        end
        if (push_acc) begin
            q.push_back(d);
            m_wptr++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(0, '0, 0, tag);
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.in_valid = 0;
        bus.in_data  = '0;
        bus.pop      = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals [3];
        vals[0] = 4'h3;
        vals[1] = 4'h7;
        vals[2] = 4'hA;
        for (int i = 0; i < 3; i++) step(1, vals[i], 0, "basic_push");
        for (int i = 0; i < 3; i++) step(0, '0, 1, "basic_pop");
        idle("basic_tail");
        idle("basic_quiet");
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, "full_push");
        step(1, 4'h5, 0, "full_over");
        idle("full_hold");
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, "full_pop");
        idle("full_tail");
        step(0, '0, 1, "empty_pop");
        idle("empty_after");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) step(1, DW'($urandom), 0, "wrap_push12");
        for (int i = 0; i < 12; i++) step(0, '0, 1, "wrap_pop12");
        for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, "wrap_push8");
        for (int i = 0; i < 8; i++) step(0, '0, 1, "wrap_pop8");
        idle("wrap_tail");
    endtask

    task automatic test_simultaneous();
        step(1, 4'h9, 0, "simul_fill");
        step(1, 4'h4, 0, "simul_fill");
        step(1, 4'hC, 1, "simul_both_cnt2");
        step(0, '0, 1, "simul_drain");
        idle("simul_gap");
        step(1, 4'hE, 1, "simul_both_empty");
        step(0, '0, 1, "simul_drain2");
        idle("simul_tail");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), DW'($urandom),
                 ($urandom_range(0, 99) < 45), "random");
        end
        while (q.size() != 0) step(0, '0, 1, "random_drain");
        idle("random_tail");
    endtask

    task automatic test_async_reset();
        step(1, 4'h1, 0, "ares_fill");
        step(1, 4'h2, 0, "ares_fill");
        step(0, '0, 1, "ares_pop");
        // Mid-cycle, no clock edge between assertion and check.
        rst_n = 0;
        model_reset();
        #1;
        check_state("ares_during");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        step(0, '0, 1, "ares_pop_after");
        idle("ares_tail");
        step(1, 4'h6, 0, "ares_first_push");
        step(0, '0, 1, "ares_pop_new");
        idle("ares_end");
    endtask

    initial begin
        clk = 0;
        vectors = 0;
        errors = 0;
        ram_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: RAM address width; FIFO depth is DEPTH = 1<<ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 4: entry width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers in_data.
REQ-006 in_data  input  DATA_WIDTH  entry to enqueue.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 pop  input  1  consumer requests one entry.
REQ-009 out_valid  output  1  out_data holds a popped entry this cycle.
REQ-010 out_data  output  DATA_WIDTH  popped entry, meaningful only while out_valid=1.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
REQ-014 ram_wr_en  output  1  to downstream single-port RAM write enable.
REQ-015 ram_addr  output  ADDR_WIDTH  to RAM address.
REQ-016 ram_wdata  output  DATA_WIDTH  to RAM write data.
REQ-017 ram_rdata  input  DATA_WIDTH  from RAM registered read data (1-cycle latency, updated only on non-write cycles).

Function
REQ-018 Internal state SHALL be wr_ptr, rd_ptr (ADDR_WIDTH each, wrap modulo DEPTH), count, and a 1-bit read-pending flag.
REQ-019 pop_acc = pop AND NOT empty; push_acc = in_valid AND in_ready.
REQ-020 in_ready SHALL equal NOT full AND NOT pop_acc (pop has priority; RAM is single-port, one access per cycle).
REQ-021 When push_acc: ram_wr_en=1, ram_addr=wr_ptr, ram_wdata=in_data; at the edge wr_ptr increments and count increments.
REQ-022 When pop_acc: ram_wr_en=0, ram_addr=rd_ptr; at the edge rd_ptr increments, count decrements, read-pending sets.
REQ-023 When neither: ram_wr_en=0, ram_addr=rd_ptr, ram_wdata=in_data; no state change except read-pending clears.
REQ-024 Read-pending SHALL be set exactly in the cycle after a pop_acc and cleared otherwise; out_valid SHALL equal read-pending.
REQ-025 out_data SHALL equal ram_rdata (combinational pass-through); one pop_acc yields exactly one out_valid cycle, latency 1 clock.
REQ-026 Back-to-back pops SHALL yield back-to-back out_valid cycles with entries in FIFO order.
REQ-027 pop on empty SHALL be ignored: no pointer/count change, no out_valid.
REQ-028 in_valid on full SHALL be ignored: in_ready=0, ram_wr_en=0, no state change.
REQ-029 pop and in_valid in same cycle with entries present: only the pop is served; producer holds in_data until in_ready=1.
REQ-030 pop and in_valid in same cycle with empty=1: the push is served (pop_acc=0).
REQ-031 Pointers SHALL wrap DEPTH-1 -> 0 without affecting count; full/empty derive from count only.
REQ-032 ram_wr_en, ram_addr, ram_wdata, in_ready SHALL be combinational from current state and inputs; count, full, empty, out_valid registered-state derived.

Reset
REQ-033 While rst_n=0, immediately and independent of clk: wr_ptr=0, rd_ptr=0, count=0, read-pending=0, so out_valid=0, empty=1, full=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries and any pending read; RAM contents are not cleared and are not required to be.
REQ-035 First push after rst_n rises SHALL write RAM address 0.

Verification
REQ-036 Reset, then push 0x3,0x7,0xA on consecutive cycles -> ram_addr 0,1,2 with ram_wr_en=1, count=3, empty=0.
REQ-037 Then pop three consecutive cycles -> out_valid high on cycles 2-4, out_data 0x3,0x7,0xA, count=0, empty=1.
REQ-038 Push 16 entries (0x0..0xF) -> full=1, in_ready=0; 17th push with 0x5 -> no write, count stays 16; pop all 16 -> order 0x0..0xF.
REQ-039 Wrap: push 12, pop 12, push 8 -> writes to addresses 12..15,0..3; pop 8 returns them in order, count=0.
REQ-040 Simultaneous in_valid and pop with count=2 -> in_ready=0, pop served, count=1; same with count=0 -> push served, out_valid stays 0.
REQ-041 Assert rst_n=0 asynchronously in cycle after a pop_acc -> out_valid drops immediately, count=0, empty=1; pop after release -> ignored.
